mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter IBURST, default 4, meaning the number of instruction-refill beats held under one grant (power of two, 1..16).
REQ-002 SHALL have parameter RR_ENABLE, default 1, meaning 1 = round-robin on ties and 0 = data port has fixed priority.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have ports i_valid (input, 1), i_addr (input, 32), i_ready (output, 1) and i_rdata (output, 32), forming the instruction-cache refill port; this port is read-only.
REQ-006 SHALL have ports d_valid (input, 1), d_addr (input, 32), d_wdata (input, 32), d_wstrb (input, 4), d_ready (output, 1) and d_rdata (output, 32), forming the data port; d_wstrb=0 means read and nonzero means write.
REQ-007 SHALL have ports mem_valid (output, 1), mem_addr (output, 32), mem_wdata (output, 32), mem_wstrb (output, 4), mem_ready (input, 1) and mem_rdata (input, 32), forming the shared memory port.
REQ-008 SHALL have port grant_d, output, 1 bit: 1 while the data port owns the memory port.

Function
REQ-009 SHALL implement states IDLE, I_ACCESS, I_GAP and D_ACCESS, with all outputs registered.
REQ-010 SHALL, in IDLE, qualify requests as i_req = i_valid & ~i_ready and d_req = d_valid & ~d_ready, so that a requester is ignored during its own ready pulse.
REQ-011 SHALL, in IDLE with only one qualified request, move to that port's ACCESS state on the next edge.
REQ-012 SHALL resolve IDLE ties as follows: RR_ENABLE=1 grants the port not served last (instruction wins after reset); RR_ENABLE=0 always grants data.
REQ-013 SHALL, on entering an ACCESS state, drive mem_valid=1 and latch mem_addr, mem_wdata and mem_wstrb from the granted port; for the instruction port mem_wdata=0 and mem_wstrb=0.
REQ-014 SHALL hold mem_valid and the mem_* outputs stable until a clock edge samples mem_ready=1; mem_ready while mem_valid=0 SHALL be ignored.
REQ-015 SHALL, on the edge where mem_valid and mem_ready are both 1, clear mem_valid, capture mem_rdata into the granted port's rdata, and pulse that port's ready for exactly one cycle; minimum access latency is therefore 2 cycles from request to ready.
REQ-016 SHALL make D_ACCESS completion always return to IDLE.
REQ-017 SHALL count instruction beats with a counter cleared on grant; when a beat completes with the count at IBURST-1, the block returns to IDLE, and otherwise it increments the count and moves to I_GAP.
REQ-018 SHALL, in I_GAP, return to I_ACCESS with i_addr latched when i_valid=1 and i_ready=0; d_valid SHALL NOT preempt during I_GAP.
REQ-019 SHALL, in I_GAP, release the lock and return to IDLE when i_valid is low for 2 consecutive cycles (abandoned refill), with the beat count discarded.
REQ-020 SHALL make grant_d=1 exactly while in D_ACCESS.
REQ-021 SHALL NOT alter any captured rdata register except on its own port's completion.
REQ-022 SHALL NOT require the requester to hold its address stable after grant, because the address is latched at grant.

Reset
REQ-023 SHALL, while reset=1 and independent of clk, force state=IDLE, mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, i_ready=0, d_ready=0, i_rdata=0, d_rdata=0, grant_d=0, the beat count to 0 and last-served to data (so instruction wins the first tie).
REQ-024 SHALL abandon any in-flight access when reset is asserted mid-operation, without generating a ready pulse; mem_valid SHALL drop asynchronously.
REQ-025 SHALL leave IDLE no earlier than the first rising edge after reset deasserts.

Verification
REQ-026 Bench SHALL cover a single data write: d_valid=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_wstrb=0xF, mem_ready on 3rd cycle -> mem_* shows those values, d_ready pulses 1 cycle, grant_d falls.
REQ-027 Bench SHALL cover a full refill with IBURST=4: icache issues 0x200, 0x204, 0x208, 0x20C with 1-cycle gaps while d_valid=1 throughout -> 4 consecutive instruction beats, then data is granted.
REQ-028 Bench SHALL cover tie arbitration: i_valid and d_valid both rise in the same cycle after reset with RR_ENABLE=1 -> instruction granted first; a repeat tie -> data granted; with RR_ENABLE=0 -> data granted both times.
REQ-029 Bench SHALL cover an abandoned refill: i_valid low for 2 cycles in I_GAP after beat 1 -> IDLE, and a pending d_valid is granted on the next edge.
REQ-030 Bench SHALL cover reset mid-access: reset=1 while mem_valid=1 -> mem_valid=0 immediately, no ready pulse; after release, a fresh i_valid access completes normally.
REQ-031 Bench SHALL cover a stalled memory: mem_ready held 0 for 10 cycles -> mem_addr, mem_wdata and mem_wstrb stay constant and no ready pulses.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: instruction, data and shared memory port signals of the arbiter.
interface mem_port_arbiter_if;
    logic        i_valid, i_ready, d_valid, d_ready, mem_valid, mem_ready, grant_d;
    logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  d_wstrb, mem_wstrb;
    modport slave (
        input  i_valid, i_addr, d_valid, d_addr, d_wdata, d_wstrb, mem_ready, mem_rdata,
        output i_ready, i_rdata, d_ready, d_rdata, mem_valid, mem_addr, mem_wdata, mem_wstrb, grant_d
    );
    modport master (
        output i_valid, i_addr, d_valid, d_addr, d_wdata, d_wstrb, mem_ready, mem_rdata,
        input  i_ready, i_rdata, d_ready, d_rdata, mem_valid, mem_addr, mem_wdata, mem_wstrb, grant_d
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between an icache refill port (burst-locked) and a data port.
module mem_port_arbiter #(
    parameter int IBURST    = 4,
    parameter bit RR_ENABLE = 1'b1
) (
    input logic clk,
    input logic reset,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, I_ACCESS, I_GAP, D_ACCESS} state_t;
    localparam logic [3:0] LAST_BEAT = 4'(IBURST - 1);
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d, mem_wstrb_q, mem_wstrb_d;
    logic        last_d_q, last_d_d, lo_q, lo_d, grant_d_q, grant_d_d;
    logic        mem_valid_q, mem_valid_d, i_ready_q, i_ready_d, d_ready_q, d_ready_d;
    logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [31:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    logic        i_req, d_req, done, grab_i, grab_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d_d    = last_d_q;
        lo_d        = 1'b0;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        i_ready_d   = 1'b0;
        d_ready_d   = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_req       = bus.i_valid & ~i_ready_q;
        d_req       = bus.d_valid & ~d_ready_q;
        done        = mem_valid_q & bus.mem_ready;
        grab_i      = 1'b0;
        grab_d      = 1'b0;
        case (state_q)
            IDLE: begin
                // Data wins a tie unless round-robin says instruction is owed the slot.
                grab_d = d_req & (~i_req | ~RR_ENABLE | ~last_d_q);
                grab_i = i_req & ~grab_d;
            end
            I_ACCESS: if (done) begin
                i_ready_d   = 1'b1;
                i_rdata_d   = bus.mem_rdata;
                mem_valid_d = 1'b0;
                cnt_d       = cnt_q + 4'd1;
                state_d     = (cnt_q == LAST_BEAT) ? IDLE : I_GAP;
            end
            I_GAP: begin
                // Refill stays locked; two idle cycles in a row mean the icache gave up.
                lo_d   = ~bus.i_valid;
                grab_i = i_req;
                if (~bus.i_valid & lo_q) state_d = IDLE;
            end
            D_ACCESS: if (done) begin
                d_ready_d   = 1'b1;
                d_rdata_d   = bus.mem_rdata;
                mem_valid_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (grab_i) begin
            state_d     = I_ACCESS;
            mem_valid_d = 1'b1;
            mem_addr_d  = bus.i_addr;
            mem_wdata_d = 32'h0;
            mem_wstrb_d = 4'h0;
            last_d_d    = 1'b0;
            if (state_q == IDLE) cnt_d = 4'd0;
        end
        if (grab_d) begin
            state_d     = D_ACCESS;
            mem_valid_d = 1'b1;
            mem_addr_d  = bus.d_addr;
            mem_wdata_d = bus.d_wdata;
            mem_wstrb_d = bus.d_wstrb;
            last_d_d    = 1'b1;
        end
        grant_d_d = (state_d == D_ACCESS);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            last_d_q    <= 1'b1;
            lo_q        <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_wstrb_q <= 4'h0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
            i_rdata_q   <= 32'h0;
            d_rdata_q   <= 32'h0;
            grant_d_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_d_q    <= last_d_d;
            lo_q        <= lo_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            i_ready_q   <= i_ready_d;
            d_ready_q   <= d_ready_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            grant_d_q   <= grant_d_d;
        end
    end

    assign bus.mem_valid = mem_valid_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wstrb = mem_wstrb_q;
    assign bus.i_ready   = i_ready_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_ready   = d_ready_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.grant_d   = grant_d_q;
endmodule
